// File: rtl/triangle_setup.sv
// Triangle setup: captures one triangle, derives its three edge equations one per
// cycle, then produces bbox/area, culls or hands the result to the rasteriser.
module triangle_setup (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [447:0] tri_data,
  input  logic         tri_valid,
  output logic         tri_ready,
  input  logic [11:0]  win_width,
  input  logic [11:0]  win_height,
  input  logic         cull_backface,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [47:0]  out_bbox,
  output logic [38:0]  out_edge_a,
  output logic [38:0]  out_edge_b,
  output logic [74:0]  out_edge_c,
  output logic [25:0]  out_area,
  output logic [95:0]  out_colour,
  output logic [15:0]  culled_count,
  output logic         busy,
  output logic [2:0]   state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds data stable while valid is high and ready is low.

  typedef enum logic [2:0] {IDLE, EDGE0, EDGE1, EDGE2, FINISH, OUT} state_t;

  state_t cur_state, next_state;

  logic [2:0][11:0] vx, vy;
  logic [11:0]      win_w, win_h;
  logic             cull_en;

  logic [11:0] xi, yi, xj, yj;
  logic [12:0] edge_a, edge_b;
  logic [23:0] prod_ij, prod_ji;
  logic [24:0] edge_c;

  logic [25:0] area_sum;
  logic [11:0] min_x, min_y, max_x, max_y, max_x_cl, max_y_cl;
  logic [11:0] win_w_m1, win_h_m1;
  logic        cull;
  logic        accept;

  // Vertex words carry more than x/y, and bits between the vertices and the
  // three 32-bit colours in the low word are padding; none of it is needed.
  logic unused_bits;
  assign unused_bits = ^{tri_data[435:416], tri_data[403:384], tri_data[371:352],
                         tri_data[339:320], tri_data[307:288], tri_data[275:96]};

  assign accept = tri_valid && tri_ready;

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur_state <= IDLE;
    else          cur_state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    if (tri_valid) next_state = EDGE0;
      EDGE0:   next_state = EDGE1;
      EDGE1:   next_state = EDGE2;
      EDGE2:   next_state = FINISH;
      FINISH:  next_state = cull ? IDLE : OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    tri_ready = (cur_state == IDLE);
    busy      = (cur_state != IDLE);
    out_valid = (cur_state == OUT);
    state     = cur_state;
  end

  // Capture is the only point where upstream inputs enter the datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vx         <= '0;
      vy         <= '0;
      win_w      <= '0;
      win_h      <= '0;
      cull_en    <= 1'b0;
      out_colour <= '0;
    end else if (accept) begin
      vx[0]      <= tri_data[447:436];
      vy[0]      <= tri_data[415:404];
      vx[1]      <= tri_data[383:372];
      vy[1]      <= tri_data[351:340];
      vx[2]      <= tri_data[319:308];
      vy[2]      <= tri_data[287:276];
      win_w      <= win_width;
      win_h      <= win_height;
      cull_en    <= cull_backface;
      out_colour <= tri_data[95:0];
    end
  end

  // Edge endpoint select: (0,1), (1,2), (2,0)
  always_comb begin
    xi = vx[0];
    yi = vy[0];
    xj = vx[1];
    yj = vy[1];
    case (cur_state)
      EDGE1: begin
        xi = vx[1];
        yi = vy[1];
        xj = vx[2];
        yj = vy[2];
      end
      EDGE2: begin
        xi = vx[2];
        yi = vy[2];
        xj = vx[0];
        yj = vy[0];
      end
      default: ;
    endcase
  end

  assign edge_a  = {1'b0, yi} - {1'b0, yj};
  assign edge_b  = {1'b0, xj} - {1'b0, xi};
  assign prod_ij = {12'd0, xi} * {12'd0, yj};
  assign prod_ji = {12'd0, xj} * {12'd0, yi};
  assign edge_c  = {1'b0, prod_ij} - {1'b0, prod_ji};

  assign area_sum = {out_edge_c[74], out_edge_c[74:50]}
                  + {out_edge_c[49], out_edge_c[49:25]}
                  + {out_edge_c[24], out_edge_c[24:0]};

  always_comb begin
    min_x = vx[0];
    min_y = vy[0];
    max_x = vx[0];
    max_y = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < min_x) min_x = vx[i];
      if (vy[i] < min_y) min_y = vy[i];
      if (vx[i] > max_x) max_x = vx[i];
      if (vy[i] > max_y) max_y = vy[i];
    end
  end

  // A zero window wraps win-1 to 4095; such triangles are culled regardless.
  assign win_w_m1 = win_w - 12'd1;
  assign win_h_m1 = win_h - 12'd1;
  assign max_x_cl = (max_x > win_w_m1) ? win_w_m1 : max_x;
  assign max_y_cl = (max_y > win_h_m1) ? win_h_m1 : max_y;

  assign cull = (area_sum == 26'd0) || (cull_en && area_sum[25]) ||
                (win_w == 12'd0) || (win_h == 12'd0) ||
                (min_x > win_w_m1) || (min_y > win_h_m1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_edge_a   <= '0;
      out_edge_b   <= '0;
      out_edge_c   <= '0;
      out_area     <= '0;
      out_bbox     <= '0;
      culled_count <= '0;
    end else begin
      case (cur_state)
        EDGE0: begin
          out_edge_a[38:26] <= edge_a;
          out_edge_b[38:26] <= edge_b;
          out_edge_c[74:50] <= edge_c;
        end
        EDGE1: begin
          out_edge_a[25:13] <= edge_a;
          out_edge_b[25:13] <= edge_b;
          out_edge_c[49:25] <= edge_c;
        end
        EDGE2: begin
          out_edge_a[12:0] <= edge_a;
          out_edge_b[12:0] <= edge_b;
          out_edge_c[24:0] <= edge_c;
        end
        FINISH: begin
          out_area <= area_sum;
          out_bbox <= {min_x, min_y, max_x_cl, max_y_cl};
          if (cull) culled_count <= culled_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: directed triangles plus randomized ones, checked
// against an integer reference model through an expected queue.
module tb_triangle_setup;

  logic         clock;
  logic         reset_n;
  logic [447:0] tri_data;
  logic         tri_valid;
  logic         tri_ready;
  logic [11:0]  win_width;
  logic [11:0]  win_height;
  logic         cull_backface;
  logic         out_valid;
  logic         out_ready;
  logic [47:0]  out_bbox;
  logic [38:0]  out_edge_a;
  logic [38:0]  out_edge_b;
  logic [74:0]  out_edge_c;
  logic [25:0]  out_area;
  logic [95:0]  out_colour;
  logic [15:0]  culled_count;
  logic         busy;
  logic [2:0]   state;

  triangle_setup dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .tri_data      (tri_data),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .win_width     (win_width),
    .win_height    (win_height),
    .cull_backface (cull_backface),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bbox      (out_bbox),
    .out_edge_a    (out_edge_a),
    .out_edge_b    (out_edge_b),
    .out_edge_c    (out_edge_c),
    .out_area      (out_area),
    .out_colour    (out_colour),
    .culled_count  (culled_count),
    .busy          (busy),
    .state         (state)
  );

  typedef struct packed {
    logic        culled;
    logic [47:0] bbox;
    logic [38:0] ea;
    logic [38:0] eb;
    logic [74:0] ec;
    logic [25:0] area;
    logic [95:0] colour;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int culled_model = 0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: edge equations from the vertex rules, area from the cross product.
  function automatic exp_t model(input int x[3], input int y[3], input logic [95:0] col,
                                 input int ww, input int wh, input bit cull);
    exp_t e;
    int a[3], b[3], c[3];
    int area, mnx, mny, mxx, mxy;
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (i + 1) % 3;
      a[i] = y[i] - y[j];
      b[i] = x[j] - x[i];
      c[i] = x[i] * y[j] - x[j] * y[i];
    end
    area = (x[1] - x[0]) * (y[2] - y[0]) - (x[2] - x[0]) * (y[1] - y[0]);
    mnx = x[0]; mny = y[0]; mxx = x[0]; mxy = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < mnx) mnx = x[i];
      if (y[i] < mny) mny = y[i];
      if (x[i] > mxx) mxx = x[i];
      if (y[i] > mxy) mxy = y[i];
    end
    if (mxx > ww - 1) mxx = ww - 1;
    if (mxy > wh - 1) mxy = wh - 1;
    e.culled = (area == 0) || (cull && area < 0) || ww == 0 || wh == 0 ||
               mnx > ww - 1 || mny > wh - 1;
    e.bbox   = {12'(mnx), 12'(mny), 12'(mxx), 12'(mxy)};
    e.ea     = {13'(a[0]), 13'(a[1]), 13'(a[2])};
    e.eb     = {13'(b[0]), 13'(b[1]), 13'(b[2])};
    e.ec     = {25'(c[0]), 25'(c[1]), 25'(c[2])};
    e.area   = 26'(area);
    e.colour = col;
    return e;
  endfunction

  function automatic logic [447:0] pack_tri(input int x[3], input int y[3], input logic [95:0] col);
    logic [447:0] d;
    for (int i = 0; i < 14; i++) d[i*32 +: 32] = $urandom();
    d[447:436] = 12'(x[0]); d[415:404] = 12'(y[0]);
    d[383:372] = 12'(x[1]); d[351:340] = 12'(y[1]);
    d[319:308] = 12'(x[2]); d[287:276] = 12'(y[2]);
    d[95:0] = col;
    return d;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < 14; i++) tri_data[i*32 +: 32] = $urandom();
    win_width     = 12'($urandom());
    win_height    = 12'($urandom());
    cull_backface = 1'($urandom());
  endtask

  // Driver: called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
  task automatic run_tri(input int x[3], input int y[3], input int ww, input int wh,
                         input bit cull, input int hold);
    logic [95:0] col;
    exp_t e;
    col = {$urandom(), $urandom(), $urandom()};
    exp_q.push_back(model(x, y, col, ww, wh, cull));
    tri_data      = pack_tri(x, y, col);
    win_width     = 12'(ww);
    win_height    = 12'(wh);
    cull_backface = cull;
    tri_valid     = 1'b1;
    check_eq("ready_idle", 128'(tri_ready), 128'(1));
    @(posedge clock); #1;
    tri_valid = 1'b0;
    scramble_inputs();
    check_eq("busy_after_accept", 128'(busy), 128'(1));
    check_eq("ready_busy", 128'(tri_ready), 128'(0));
    repeat (3) @(posedge clock);
    #1;
    check_eq("no_early_valid", 128'(out_valid), 128'(0));
    @(posedge clock); #1;
    e = exp_t'(exp_q.pop_front());
    if (e.culled) begin
      culled_model++;
      check_eq("cull_valid", 128'(out_valid), 128'(0));
      check_eq("cull_ready", 128'(tri_ready), 128'(1));
      check_eq("cull_area", 128'(out_area), 128'(e.area));
      check_eq("cull_count", 128'(culled_count), 128'(16'(culled_model)));
    end else begin
      check_eq("valid", 128'(out_valid), 128'(1));
      check_eq("count_kept", 128'(culled_count), 128'(16'(culled_model)));
      for (int h = 0; h <= hold; h++) begin
        check_eq("hold_valid", 128'(out_valid), 128'(1));
        check_eq("hold_ready", 128'(tri_ready), 128'(0));
        check_eq("bbox", 128'(out_bbox), 128'(e.bbox));
        check_eq("edge_a", 128'(out_edge_a), 128'(e.ea));
        check_eq("edge_b", 128'(out_edge_b), 128'(e.eb));
        check_eq("edge_c", 128'(out_edge_c), 128'(e.ec));
        check_eq("area", 128'(out_area), 128'(e.area));
        check_eq("colour", 128'(out_colour), 128'(e.colour));
        if (h < hold) begin
          out_ready = 1'b0;
          tri_valid = 1'($urandom());
          @(posedge clock); #1;
        end
      end
      tri_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check_eq("post_hs_valid", 128'(out_valid), 128'(0));
      check_eq("post_hs_ready", 128'(tri_ready), 128'(1));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 128'(out_valid), 128'(0));
    check_eq({tag, "_ready"}, 128'(tri_ready), 128'(1));
    check_eq({tag, "_busy"}, 128'(busy), 128'(0));
    check_eq({tag, "_count"}, 128'(culled_count), 128'(0));
    check_eq({tag, "_data"}, 128'({out_bbox, out_edge_a, out_area}), 128'(0));
    check_eq({tag, "_edge"}, 128'({out_edge_b, out_edge_c}), 128'(0));
    check_eq({tag, "_colour"}, 128'(out_colour), 128'(0));
  endtask

  initial begin
    int x[3], y[3];
    int ww, wh;
    reset_n = 1'b0;
    tri_valid = 1'b0;
    out_ready = 1'b0;
    tri_data = '0;
    win_width = 12'd640;
    win_height = 12'd480;
    cull_backface = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    x = '{10, 20, 10}; y = '{10, 10, 20};
    run_tri(x, y, 640, 480, 1'b0, 0);
    x = '{10, 10, 20}; y = '{10, 20, 10};
    run_tri(x, y, 640, 480, 1'b1, 0);
    run_tri(x, y, 640, 480, 1'b0, 1);
    x = '{0, 5, 10}; y = '{0, 5, 10};
    run_tri(x, y, 640, 480, 1'b0, 0);
    x = '{600, 700, 600}; y = '{400, 400, 500};
    run_tri(x, y, 640, 480, 1'b0, 2);
    x = '{700, 800, 700}; y = '{10, 10, 20};
    run_tri(x, y, 640, 480, 1'b0, 0);
    x = '{10, 20, 10}; y = '{10, 10, 20};
    run_tri(x, y, 0, 480, 1'b0, 0);
    run_tri(x, y, 640, 480, 1'b0, 10);

    // Reset during EDGE1 drops the triangle and clears the counter.
    x = '{10, 20, 10}; y = '{10, 10, 20};
    tri_data = pack_tri(x, y, 96'hABCD);
    tri_valid = 1'b1;
    @(posedge clock); #1;
    tri_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    culled_model = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_tri(x, y, 640, 480, 1'b1, 0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          x[i] = $urandom_range(0, 4095);
          y[i] = $urandom_range(0, 4095);
        end else begin
          x[i] = $urandom_range(0, 700);
          y[i] = $urandom_range(0, 520);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        ww = $urandom_range(0, 1) ? 0 : 640;
        wh = (ww == 0) ? 480 : 0;
      end else if ($urandom_range(0, 1) == 0) begin
        ww = $urandom_range(1, 1024);
        wh = $urandom_range(1, 1024);
      end else begin
        ww = 640;
        wh = 480;
      end
      run_tri(x, y, ww, wh, 1'($urandom()), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
